fpdiv_seq_ctrl: RTL

FPDIV_SEQ_CTRL -- requirements
Module: fpdiv_seq_ctrl

---
 rtl/fpdiv_pkg.sv | 28 ++
 rtl/fpdiv_special.sv | 39 +++
 rtl/fpdiv_seq_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpdiv_pkg.sv
// Shared definitions for the sequential single-precision divider controller.
// Holds FSM encoding, divider constants and IEEE754 operand field helpers.
package fpdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      NORM = 2'd2
   } state_t;

   localparam int          BIAS   = 127;
   localparam int          ITER_N = 24;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;

   // Denormals have exp=0 and are flushed, so they classify as zero.
   function automatic logic fp_is_zero(input logic [31:0] v);
      return v[30:23] == 8'h00;
   endfunction

   function automatic logic fp_is_inf(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
   endfunction

   function automatic logic fp_is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/fpdiv_special.sv
// Combinational operand classifier: flags pairs that bypass the iterative
// datapath and supplies their final quotient.
module fpdiv_special
   import fpdiv_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        is_special,
   output logic [31:0] special_result
);

   logic a_zero, a_inf, a_nan;
   logic b_zero, b_inf, b_nan;
   logic sign;

   assign a_zero = fp_is_zero(a);
   assign a_inf  = fp_is_inf(a);
   assign a_nan  = fp_is_nan(a);
   assign b_zero = fp_is_zero(b);
   assign b_inf  = fp_is_inf(b);
   assign b_nan  = fp_is_nan(b);
   assign sign   = a[31] ^ b[31];

   always_comb begin
      is_special     = 1'b0;
      special_result = 32'd0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         is_special     = 1'b1;
         special_result = QNAN;
      end else if (a_inf || b_zero) begin
         is_special     = 1'b1;
         special_result = {sign, 8'hFF, 23'd0};
      end else if (a_zero || b_inf) begin
         is_special     = 1'b1;
         special_result = {sign, 31'd0};
      end
   end

endmodule

// File: rtl/fpdiv_seq_ctrl.sv
// Sequential IEEE754 single divider: one restoring quotient bit per clock,
// truncating, with a single-cycle bypass for special operand pairs.
//
// state | meaning
// IDLE  | waiting for start; special pairs complete here in one edge
// ITER  | restoring division, one quotient bit per edge (24 edges)
// NORM  | normalize quotient, compute exponent, register result
module fpdiv_seq_ctrl
   import fpdiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow
);

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [25:0] rem;
   logic [23:0] quo;
   logic [7:0]  exp_a, exp_b;
   logic [22:0] frac_b;
   logic        sign;

   logic        is_special;
   logic [31:0] special_result;

   logic [25:0] div_ext;
   logic        rem_ge;
   logic [25:0] rem_sub;
   logic        shift;
   logic [22:0] mant;
   logic [9:0]  exp_raw;
   logic        exp_under, exp_over;

   fpdiv_special u_special (
      .a              (A),
      .b              (B),
      .is_special     (is_special),
      .special_result (special_result)
   );

   assign div_ext = {2'b00, 1'b1, frac_b};
   assign rem_ge  = rem >= div_ext;
   assign rem_sub = rem_ge ? (rem - div_ext) : rem;

   // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift.
   assign shift     = ~quo[23];
   assign mant      = quo[23] ? quo[22:0] : {quo[21:0], 1'b0};
   assign exp_raw   = {2'b00, exp_a} - {2'b00, exp_b} + 10'(BIAS) - {9'd0, shift};
   assign exp_under = exp_raw[9] || (exp_raw == 10'd0);
   assign exp_over  = !exp_raw[9] && (exp_raw >= 10'd255);

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start && !is_special) state_nxt = ITER;
         ITER: if (cnt == 5'(ITER_N - 1)) state_nxt = NORM;
         NORM: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         exp_a     <= '0;
         exp_b     <= '0;
         frac_b    <= '0;
         sign      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_special) begin
                     result    <= special_result;
                     overflow  <= 1'b0;
                     underflow <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     sign   <= A[31] ^ B[31];
                     exp_a  <= A[30:23];
                     exp_b  <= B[30:23];
                     frac_b <= B[22:0];
                     rem    <= {2'b00, 1'b1, A[22:0]};
                     quo    <= '0;
                     cnt    <= '0;
                  end
               end
            end
            ITER: begin
               quo <= {quo[22:0], rem_ge};
               rem <= {rem_sub[24:0], 1'b0};
               cnt <= cnt + 5'd1;
            end
            NORM: begin
               cnt  <= '0;
               done <= 1'b1;
               if (exp_under) begin
                  result    <= {sign, 31'd0};
                  overflow  <= 1'b0;
                  underflow <= 1'b1;
               end else if (exp_over) begin
                  result    <= {sign, 8'hFF, 23'd0};
                  overflow  <= 1'b1;
                  underflow <= 1'b0;
               end else begin
                  result    <= {sign, exp_raw[7:0], mant};
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
